mod_w_mem: RTL and testbench
============================

# mod_w_mem

SHA-256 message-schedule memory: holds the 64 × 32-bit schedule words W[0..63] for one block. The host loads W[0..15] through an indexed write port. The block then expands W[16..63] internally at one word per clock. The compressor reads any word by 6-bit index during its 64 rounds.

## Interface
Parameters: none. Word count is 64 and word width is 32, fixed by SHA-256.

Ports:
- CLK  input  1  — single clock; all state changes on its rising edge.
- RST  input  1  — asynchronous, active-high reset.
- WI  input  6  — word index for both read and write (0..63).
- D_IN  input  32  — write data.
- WE  input  1  — write enable: W[WI] ← D_IN at the edge.
- EXP_START  input  1  — request expansion of W[16..63].
- D_OUT  output  32  — W[WI], combinational read.
- BUSY  output  1  — expansion in progress.
- DONE  output  1  — one-cycle pulse after W[63] is written.

## Operation
- Storage: 64 words of flops, not inferred RAM, so that the whole array can be asynchronously reset.
- Read: D_OUT = W[WI] at all times, including during expansion. Contents are always current, with no read latency.
- Write, when idle: if WE=1 and BUSY=0, W[WI] ← D_IN. Any index 0..63 is writable. WE is ignored while BUSY=1.
- Expansion: one word per cycle for t = 16..63, using the formula below.
  - W[t] = σ1(W[t−2]) + W[t−7] + σ0(W[t−15]) + W[t−16], mod 2^32; carries are discarded.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Internal 6-bit counter t runs 16..63. Each expansion write uses the values already stored, so each word sees all previously computed words.
- States:
  - IDLE → EXPAND on EXP_START=1.
  - EXPAND → IDLE after the t=63 write.
  - EXP_START during EXPAND is ignored.
- WE and EXP_START both high in IDLE: the write happens at that edge and expansion begins. The expansion therefore uses the newly written value.
- Re-running expansion without reloading is legal. It recomputes W[16..63] from the current W[0..15].

## Timing
- Reset (async assert, synchronous deassert is the integrator's concern):
  - all W = 0, t = 16, state IDLE;
  - BUSY = 0, DONE = 0, D_OUT = 0.
- EXP_START sampled high at edge k in IDLE:
  - BUSY = 1 from after edge k;
  - W[16+i] is written at edge k+1+i, for i = 0..47;
  - W[63] is written at edge k+48.
- After edge k+48: BUSY = 0 and DONE = 1 for exactly one cycle. The next EXP_START is accepted at edge k+49 or later. Total expansion is 48 cycles.
- Reset during EXPAND: aborts immediately, clears all words, returns to IDLE. No DONE pulse.
- D_OUT changes in the same cycle as WI, and one edge after a write to the addressed word.

## Structure
- Shared package sha256_pkg:
  - W_WORDS = 64, W_INIT = 16;
  - functions sig0/sig1 (σ0/σ1);
  - state enum {IDLE, EXPAND}.
- One natural sub-module: sha256_w_next. It is a combinational datapath taking W[t−2], W[t−7], W[t−15], W[t−16] and returning W[t].
- Top module holds the array, the counter and the FSM.

## Test plan
- Reset: assert RST mid-cycle → D_OUT = 0 for every WI, BUSY = 0, DONE = 0 immediately.
- Write/read: write 0xDEADBEEF to WI=5 and 0x01234567 to WI=63 → reading back gives the same values; other indices stay 0.
- "abc" block: load W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, then pulse EXP_START. Required results:
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405;
  - all 48 words match a reference model.
- Timing: EXP_START at edge k → BUSY high for edges k+1..k+48; DONE high only in the cycle after edge k+48; W[20] becomes valid at edge k+5.
- Busy lockout: WE to WI=3 and a second EXP_START during EXPAND → W3 unchanged; completion still at edge k+48.
- Abort: RST at cycle 20 of expansion → all words 0, no DONE. A fresh load and expand then produces correct results.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: sizes, sigma functions, FSM states.
package sha256_pkg;

    localparam int unsigned W_WORDS = 64;
    localparam int unsigned W_INIT  = 16;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Combinational schedule step: W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [31:0] i_w2,
    input  logic [31:0] i_w7,
    input  logic [31:0] i_w15,
    input  logic [31:0] i_w16,
    output logic [31:0] o_w
);

    // Modular 32-bit sum; carries out of bit 31 are dropped.
    always_comb begin
        o_w = sig1(i_w2) + i_w7 + sig0(i_w15) + i_w16;
    end

endmodule

// File: rtl/mod_w_mem.sv
// SHA-256 message-schedule memory: 64 x 32-bit flop array, host load port,
// in-place expansion of W[16..63] at one word per clock, combinational read.
module mod_w_mem
    import sha256_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  WI,
    input  logic [31:0] D_IN,
    input  logic        WE,
    input  logic        EXP_START,
    output logic [31:0] D_OUT,
    output logic        BUSY,
    output logic        DONE
);

    logic [31:0] r_w [W_WORDS];
    state_t      r_state;
    logic [5:0]  r_t;
    logic        r_done;

    logic [5:0]  w_i2;
    logic [5:0]  w_i7;
    logic [5:0]  w_i15;
    logic [5:0]  w_i16;
    logic [31:0] w_next;

    // Source indices for the word being expanded; t >= 16 so no wrap occurs.
    always_comb begin
        w_i2  = r_t - 6'd2;
        w_i7  = r_t - 6'd7;
        w_i15 = r_t - 6'd15;
        w_i16 = r_t - 6'd16;
    end

    sha256_w_next u_w_next (
        .i_w2  (r_w[w_i2]),
        .i_w7  (r_w[w_i7]),
        .i_w15 (r_w[w_i15]),
        .i_w16 (r_w[w_i16]),
        .o_w   (w_next)
    );

    // Array, counter and FSM: host writes when idle, one expansion write per cycle when busy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < W_WORDS; i++) begin
                r_w[i] <= '0;
            end
            r_t     <= 6'(W_INIT);
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (WE) begin
                        r_w[WI] <= D_IN;
                    end
                    if (EXP_START) begin
                        r_state <= EXPAND;
                        r_t     <= 6'(W_INIT);
                    end
                end
                EXPAND: begin
                    r_w[r_t] <= w_next;
                    if (r_t == 6'd63) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_t     <= 6'(W_INIT);
                    end else begin
                        r_t <= r_t + 6'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read port and status are direct views of registered state.
    always_comb begin
        D_OUT = r_w[WI];
        BUSY  = (r_state == EXPAND);
        DONE  = r_done;
    end

endmodule

// File: tb/tb_mod_w_mem.sv
// Self-checking bench for mod_w_mem against a behavioural schedule model.
`timescale 1ns/1ps
module tb_mod_w_mem;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  WI = '0;
    logic [31:0] D_IN = '0;
    logic        WE = 1'b0;
    logic        EXP_START = 1'b0;
    logic [31:0] D_OUT;
    logic        BUSY;
    logic        DONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m [64];     // reference contents
    logic [31:0] old20;

    mod_w_mem dut (
        .CLK       (CLK),
        .RST       (RST),
        .WI        (WI),
        .D_IN      (D_IN),
        .WE        (WE),
        .EXP_START (EXP_START),
        .D_OUT     (D_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model_expand();
        for (int t = 16; t < 64; t++) begin
            m[t] = s1(m[t-2]) + m[t-7] + s0(m[t-15]) + m[t-16];
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [31:0] data);
        WE = 1'b1; WI = 6'(idx); D_IN = data;
        tick();
        WE = 1'b0;
        m[idx] = data;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 64; i++) begin
            WI = 6'(i);
            #1;
            check($sformatf("%s_w%0d", tag, i), D_OUT, m[i]);
        end
    endtask

    // Launch one expansion and check cycle-accurate BUSY/DONE, W20 timing and final contents.
    task automatic expand_run(input string tag, input bit lockout, input bit same_edge_wr);
        logic [31:0] lk;
        logic [31:0] w3_before;
        old20 = m[20];
        EXP_START = 1'b1;
        if (same_edge_wr) begin
            WE = 1'b1; WI = 6'd15; D_IN = $urandom;
            m[15] = D_IN;
        end
        tick();                       // edge k
        EXP_START = 1'b0; WE = 1'b0;
        model_expand();
        w3_before = m[3];
        check({tag, "_busy_k"}, {31'b0, BUSY}, 32'd1);
        check({tag, "_done_k"}, {31'b0, DONE}, 32'd0);
        WI = 6'd20;
        for (int n = 1; n <= 48; n++) begin
            if (lockout && n == 3) begin
                lk = $urandom | 32'h1;
                WE = 1'b1; WI = 6'd3; D_IN = lk; EXP_START = 1'b1;
            end
            tick();                   // edge k+n
            WE = 1'b0; EXP_START = 1'b0; WI = 6'd20;
            #1;
            check($sformatf("%s_busy_k%0d", tag, n), {31'b0, BUSY}, (n < 48) ? 32'd1 : 32'd0);
            check($sformatf("%s_done_k%0d", tag, n), {31'b0, DONE}, (n == 48) ? 32'd1 : 32'd0);
            if (n == 4) check({tag, "_w20_pre"}, D_OUT, old20);
            if (n == 5) check({tag, "_w20_k5"}, D_OUT, m[20]);
        end
        tick();                       // edge k+49
        check({tag, "_done_clr"}, {31'b0, DONE}, 32'd0);
        check({tag, "_busy_clr"}, {31'b0, BUSY}, 32'd0);
        if (lockout) begin
            WI = 6'd3;
            #1;
            check({tag, "_w3_locked"}, D_OUT, w3_before);
        end
        read_all(tag);
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) write_word(i, $urandom);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m[i] = '0;
        #12;
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_done", {31'b0, DONE}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Basic write/read including the top index.
        write_word(5, 32'hDEADBEEF);
        write_word(63, 32'h01234567);
        read_all("wr");

        // Mid-cycle reset clears everything immediately.
        write_word(40, $urandom | 32'h1);
        #3;
        RST = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) m[i] = '0;
        check("midrst_busy", {31'b0, BUSY}, 32'd0);
        check("midrst_done", {31'b0, DONE}, 32'd0);
        read_all("midrst");
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // "abc" single-block message.
        write_word(0, 32'h61626380);
        for (int i = 1; i < 15; i++) write_word(i, 32'h0);
        write_word(15, 32'h00000018);
        expand_run("abc", 1'b0, 1'b0);
        WI = 6'd16; #1; check("abc_w16", D_OUT, 32'h61626380);
        WI = 6'd17; #1; check("abc_w17", D_OUT, 32'h000F0000);
        WI = 6'd18; #1; check("abc_w18", D_OUT, 32'h7DA86405);

        // Random block with busy-time write and restart attempts.
        load_random();
        expand_run("lock", 1'b1, 1'b0);

        // Rerun without reload.
        expand_run("rerun", 1'b0, 1'b0);

        // Random block with write and start on the same edge.
        load_random();
        expand_run("same", 1'b0, 1'b1);

        // Abort mid-expansion.
        load_random();
        EXP_START = 1'b1;
        tick();
        EXP_START = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        #3;
        RST = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) m[i] = '0;
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        check("abort_done", {31'b0, DONE}, 32'd0);
        read_all("abort");
        @(negedge CLK);
        RST = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            for (int n = 0; n < 40; n++) begin
                tick();
                if (DONE) seen_done++;
            end
            check("abort_no_done", 32'(seen_done), 32'd0);
        end

        // Fresh load and expansion after abort.
        load_random();
        expand_run("post", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
